// File: rtl/add_serial_pkg.sv
// Shared definitions for the add_serial sequencer and the adder bench.
// State encoding plus default width and adder latency.
package add_serial_pkg;

  localparam int ADD_WIDTH    = 8;
  localparam int ADD_DONE_LAT = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_CAP   = 2'd3
  } state_t;

endpackage

// File: rtl/add_serial_seq_if.sv
// Operand stream, adder drive and result stream of the add_serial sequencer.
// slave is the sequencer's view; master is the view of whoever surrounds it.
interface add_serial_seq_if
  import add_serial_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;

  modport slave (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_en, add_a, add_b, res_valid, res_sum
  );

  modport master (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_en, add_a, add_b, res_valid, res_sum
  );

endinterface

// File: rtl/add_serial_opfifo.sv
// Small synchronous operand FIFO; head is the entry at the read pointer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module add_serial_opfifo
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 2 * ADD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/add_serial_seq.sv
// Sequencer for the add_serial bit-serial adder: queues operand pairs,
// pulses the adder en to start/release and registers each result.
//
// state   | meaning
// S_IDLE  | waiting for an operand pair in the FIFO
// S_START | start pulse on add_en, operands = FIFO head (cycle 0)
// S_WAIT  | counting adder latency
// S_CAP   | capture result, release pulse and pop when output reg free
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int WIDTH    = ADD_WIDTH,
  parameter int DEPTH    = 2,
  parameter int DONE_LAT = ADD_DONE_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  add_serial_seq_if.slave      bus,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DONE_LAT) + 1;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   wait_cnt;
  logic               capture;
  logic               push;
  logic               full;
  logic               empty;
  logic [2*WIDTH-1:0] head;

  assign capture      = (state == S_CAP) && (!bus.res_valid || bus.res_ready);
  assign bus.in_ready = !full || capture;
  assign push         = bus.in_valid && bus.in_ready;

  // The operand is only popped on capture, so add_a/add_b stay put mid-operation.
  add_serial_opfifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (capture),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.add_a = head[2*WIDTH-1:WIDTH];
  assign bus.add_b = head[WIDTH-1:0];
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    bus.add_en = 1'b0;
    case (state)
      S_IDLE:  if (!empty) state_nx = S_START;
      S_START: begin
        bus.add_en = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT:  if (wait_cnt == CNT_W'(DONE_LAT - 1)) state_nx = S_CAP;
      S_CAP:   if (capture) begin
        bus.add_en = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counter equals the cycle index relative to the start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE) begin
      wait_cnt <= '0;
    end else if (state == S_START || state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
    end else if (capture) begin
      bus.res_valid <= 1'b1;
      bus.res_sum   <= bus.add_out;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_serial_seq.sv
// Bench for add_serial_seq: behavioural adder model, result scoreboard,
// directed timing scenarios and a randomized phase with random back-pressure.
module tb_add_serial_seq;
  import add_serial_pkg::*;

  localparam int W   = 8;
  localparam int LAT = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  add_serial_seq_if #(.WIDTH(W)) bus();

  add_serial_seq #(.WIDTH(W), .DEPTH(2), .DONE_LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder model: latches operands on a start pulse, output is wrong until
  // LAT cycles after the start cycle, then holds the sum until release.
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b, m_sum;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0; m_sum <= '0;
    end else if (bus.add_en) begin
      if (!m_busy) begin
        m_busy <= 1'b1; m_cnt <= 1; m_a <= bus.add_a; m_b <= bus.add_b;
        m_sum  <= W'((int'(bus.add_a) + int'(bus.add_b)) % 256);
      end else begin
        m_busy <= 1'b0;
      end
    end else if (m_busy && m_cnt < LAT) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign bus.add_out = (m_busy && m_cnt >= LAT) ? m_sum : ~m_sum;

  // Scoreboard and event logs, sampled on the falling edge.
  logic [W-1:0] exp_q[$];
  int           en_log[$];
  int           acc_log[$];
  int           push_log[$];
  logic [W-1:0] last_sum;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.add_en) begin
        en_log.push_back(cyc);
        check("en_only_idle_or_done", 32'(!m_busy || m_cnt >= LAT), 32'd1);
      end
      if (m_busy) begin
        check("add_a_stable", 32'(bus.add_a), 32'(m_a));
        check("add_b_stable", 32'(bus.add_b), 32'(m_b));
      end
      if (bus.res_valid && bus.res_ready) begin
        acc_log.push_back(cyc);
        last_sum = bus.res_sum;
        check("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("res_sum", 32'(bus.res_sum), 32'(exp_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        push_log.push_back(cyc);
        exp_q.push_back(W'((int'(bus.in_a) + int'(bus.in_b)) % 256));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 300) begin
        check("push_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || bus.res_valid) && t < 2000) begin
      @(negedge clk); t++;
    end
    check({name, "_drain_in_time"}, 32'(t < 2000), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    en_log.delete(); acc_log.delete(); push_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r;
    logic pushes_done;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    tick(3);
    check("rst_add_en",    32'(bus.add_en),    32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_sum",   32'(bus.res_sum),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    rst = 1'b1;
    tick(2);

    // Single op: en at cycles 0 and 11, result visible at cycle 12.
    bus.res_ready = 1'b1;
    clear_logs();
    push(8'h21, 8'h13);
    wait_drain("single");
    check("single_en_count",   32'(en_log.size()),           32'd2);
    check("single_release_at", 32'(en_log[1] - en_log[0]),   32'(LAT));
    check("single_result_at",  32'(acc_log[0] - en_log[0]),  32'(LAT + 1));
    check("single_sum",        32'(last_sum),                32'h34);

    // Wrap-around.
    push(8'hF0, 8'h20);
    wait_drain("wrap");
    check("wrap_sum", 32'(last_sum), 32'h10);

    // Back-to-back with a push into a full FIFO while it pops.
    clear_logs();
    push(8'h01, 8'h02);
    push(8'h10, 8'h20);
    @(negedge clk);
    check("b2b_full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    push(8'h7F, 8'h81);
    wait_drain("b2b");
    check("b2b_results",       32'(acc_log.size()),          32'd3);
    check("b2b_spacing_1",     32'(acc_log[1] - acc_log[0]), 32'(LAT + 2));
    check("b2b_spacing_2",     32'(acc_log[2] - acc_log[1]), 32'(LAT + 2));
    check("b2b_push_on_pop",   32'(push_log[2]),             32'(en_log[1]));

    // Back-pressure: second op stalls in capture until res_ready.
    clear_logs();
    bus.res_ready = 1'b0;
    push(8'h33, 8'h44);
    push(8'hAA, 8'h0B);
    tick(45);
    check("bp_en_count",   32'(en_log.size()),  32'd3);
    check("bp_res_valid",  32'(bus.res_valid),  32'd1);
    check("bp_busy",       32'(busy),           32'd1);
    check("bp_in_ready",   32'(bus.in_ready),   32'd1);
    r = cyc;
    bus.res_ready = 1'b1;
    wait_drain("bp");
    check("bp_first_accept", 32'(acc_log[0]),              32'(r));
    check("bp_release_at",   32'(en_log[3]),               32'(r));
    check("bp_second_next",  32'(acc_log[1] - acc_log[0]), 32'd1);

    // Reset five cycles into an operation.
    clear_logs();
    push(8'h55, 8'h66);
    t0 = 0;
    while (en_log.size() == 0 && t0 < 50) begin tick(1); t0++; end
    t0 = en_log[0];
    while (cyc < t0 + 5) tick(1);
    rst = 1'b0;
    #1;
    check("mid_rst_add_en",    32'(bus.add_en),    32'd0);
    check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_busy",      32'(busy),          32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b1;
    tick(1);
    clear_logs();
    push(8'h0C, 8'h0D);
    wait_drain("post_rst");
    check("post_rst_sum",     32'(last_sum),       32'h19);
    check("post_rst_results", 32'(acc_log.size()), 32'd1);

    // Randomized operands, gaps and consumer back-pressure.
    clear_logs();
    pushes_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          tick($urandom_range(0, 15));
          push(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
        pushes_done = 1'b1;
      end
      begin
        int t = 0;
        while ((!pushes_done || exp_q.size() > 0) && t < 4000) begin
          bus.res_ready = 1'($urandom_range(0, 1));
          tick(1);
          t++;
        end
      end
    join
    bus.res_ready = 1'b1;
    wait_drain("rand");
    check("rand_all_returned", 32'(acc_log.size()), 32'(push_log.size()));
    check("rand_push_count",   32'(push_log.size()), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
